// File: rtl/flag_cond_unit_pkg.sv
// Shared condition-code definitions for the flag/condition stage.
// Holds the ARM cond encodings, NZCV bit positions and the cond type.
package flag_cond_unit_pkg;

  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ = 4'h0;
  localparam cond_t COND_NE = 4'h1;
  localparam cond_t COND_CS = 4'h2;
  localparam cond_t COND_CC = 4'h3;
  localparam cond_t COND_MI = 4'h4;
  localparam cond_t COND_PL = 4'h5;
  localparam cond_t COND_VS = 4'h6;
  localparam cond_t COND_VC = 4'h7;
  localparam cond_t COND_HI = 4'h8;
  localparam cond_t COND_LS = 4'h9;
  localparam cond_t COND_GE = 4'hA;
  localparam cond_t COND_LT = 4'hB;
  localparam cond_t COND_GT = 4'hC;
  localparam cond_t COND_LE = 4'hD;
  localparam cond_t COND_AL = 4'hE;
  localparam cond_t COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition decode.
// pass = 1 when cond holds against the supplied NZCV flags.
module cond_eval
  import flag_cond_unit_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // decode the condition field against the flags
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Flag/condition stage: evaluates cond vs CPSR, updates flags, forwards.
// Optional COND_STATS_EN builds saturating exec/skip counters.
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_nzcv,
  input  logic              s_bit,
  input  cond_t             cond,
  input  logic [3:0]        rd,
  input  logic              wb_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_rd,
  output logic              out_wb_en,
  output logic              out_pass,
  output logic [3:0]        cpsr_nzcv,
  output logic [15:0]       exec_cnt,
  output logic [15:0]       skip_cnt
);

  logic accept;
  logic pass;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  cond_eval u_cond_eval (
    .cond (cond),
    .nzcv (cpsr_nzcv),
    .pass (pass)
  );

  // output register: flush wins, then accept, then drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wb_en  <= 1'b0;
      out_pass   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= alu_out;
      out_rd     <= rd;
      out_wb_en  <= wb_en & pass;
      out_pass   <= pass;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // architectural flags: only a passing S-instruction writes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_nzcv <= 4'b0000;
    end else if (accept & pass & s_bit) begin
      cpsr_nzcv <= alu_nzcv;
    end
  end

`ifdef COND_STATS_EN
  logic [15:0] exec_q;
  logic [15:0] skip_q;

  // saturating counts of executed and skipped instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q <= '0;
      skip_q <= '0;
    end else if (accept) begin
      if (pass && exec_q != 16'hFFFF) begin
        exec_q <= exec_q + 16'd1;
      end
      if (!pass && skip_q != 16'hFFFF) begin
        skip_q <= skip_q + 16'd1;
      end
    end
  end

  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;
`else
  assign exec_cnt = '0;
  assign skip_cnt = '0;
`endif

endmodule
